// File: rtl/noc_params.sv
// Network-wide parameters and flit types shared by every router block.
package noc_params;

   localparam int VC_NUM  = 4;
   localparam int VC_SIZE = $clog2(VC_NUM);
   localparam int DATA_W  = 16;

   typedef enum logic [1:0] {
      HEAD     = 2'b00,
      BODY     = 2'b01,
      TAIL     = 2'b10,
      HEADTAIL = 2'b11
   } flit_label_t;

   typedef struct packed {
      flit_label_t          flit_label;
      logic [VC_SIZE-1:0]   vc_id;
      logic [DATA_W-1:0]    data;
   } flit_t;

   // Transmit-side view of one downstream virtual channel.
   typedef enum logic [1:0] {
      FREE,
      RESERVED,
      ACTIVE,
      DRAIN
   } tx_vc_state_t;

endpackage

// File: rtl/output_port_tx_pkg.sv
// Helpers local to the output port transmitter.
package output_port_tx_pkg;

   import noc_params::*;

   localparam int FLIT_W = $bits(flit_t);

   // True when more than one bit of a VC vector is set.
   function automatic logic multi_hot(input logic [VC_NUM-1:0] v);
      return (v & (v - VC_NUM'(1))) != '0;
   endfunction

   // Flit kinds that start a packet on a reserved VC.
   function automatic logic opens_packet(input flit_label_t label);
      return (label == HEAD) || (label == HEADTAIL);
   endfunction

   // Flit kinds that end a packet and release the VC into drain.
   function automatic logic closes_packet(input flit_label_t label);
      return (label == TAIL) || (label == HEADTAIL);
   endfunction

endpackage

// File: rtl/output_port_tx_if.sv
// Crossbar-side, allocator-side and link-side signals of one output port.
interface output_port_tx_if
   import noc_params::*;
   ;

   flit_t              xb_flit_i;
   logic               xb_valid_i;
   logic [VC_NUM-1:0]  va_grant_i;
   logic [VC_NUM-1:0]  on_off_i;
   logic [VC_NUM-1:0]  vc_allocatable_i;

   flit_t              data_o;
   logic               valid_flit_o;
   logic [VC_NUM-1:0]  is_on_off_o;
   logic [VC_NUM-1:0]  is_allocatable_o;
   logic [VC_NUM-1:0]  error_o;

   // Environment side: drives crossbar, allocator and downstream status.
   modport master (
      output xb_flit_i, xb_valid_i, va_grant_i, on_off_i, vc_allocatable_i,
      input  data_o, valid_flit_o, is_on_off_o, is_allocatable_o, error_o
   );

   // Transmitter side.
   modport slave (
      input  xb_flit_i, xb_valid_i, va_grant_i, on_off_i, vc_allocatable_i,
      output data_o, valid_flit_o, is_on_off_o, is_allocatable_o, error_o
   );

endinterface

// File: rtl/output_port_tx_vc_tracker.sv
// State tracker for one downstream VC: reservation, packet progress,
// post-tail drain and sticky protocol error.
module tx_vc_tracker
   import noc_params::*;
   import output_port_tx_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        grant,
   input  logic        grant_collision,
   input  logic        flit_hit,
   input  flit_label_t flit_label,
   input  logic        on_off_q,
   input  logic        alloc_q,
   output logic        is_on_off,
   output logic        is_allocatable,
   output logic        error
);

   localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

   tx_vc_state_t     state;
   logic [CNT_W-1:0] drain_cnt;
   logic             error_q;
   logic             flit_state_ok;
   logic             grant_ok;
   logic             flit_ok;

   // Which flit kinds the current state accepts.
   // NOTE: the default assignment first keeps this block purely combinational; a path that leaves it unassigned would infer a latch.
   always_comb begin
      flit_state_ok = 1'b0;
      unique case (state)
         RESERVED: flit_state_ok = opens_packet(flit_label);
         ACTIVE:   flit_state_ok = !opens_packet(flit_label);
         default:  flit_state_ok = 1'b0;
      endcase
   end

   // A grant is legal only on an idle, downstream-empty VC and only when it
   // is the sole grant this cycle; a flit also needs downstream credit.
   assign grant_ok = grant && !grant_collision && (state == FREE) && alloc_q;
   assign flit_ok  = flit_hit && on_off_q && flit_state_ok;

   // VC state machine; illegal events only raise the sticky error.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values; reset is asynchronous and active-low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= FREE;
         drain_cnt <= '0;
         error_q   <= 1'b0;
      end else begin
         if ((grant && !grant_ok) || (flit_hit && !flit_ok))
            error_q <= 1'b1;

         unique case (state)
            FREE: begin
               if (grant_ok)
                  state <= RESERVED;
            end
            RESERVED: begin
               if (flit_ok) begin
                  if (closes_packet(flit_label)) begin
                     state     <= DRAIN;
                     drain_cnt <= CNT_W'(DRAIN_CYCLES);
                  end else begin
                     state <= ACTIVE;
                  end
               end
            end
            ACTIVE: begin
               if (flit_ok && closes_packet(flit_label)) begin
                  state     <= DRAIN;
                  drain_cnt <= CNT_W'(DRAIN_CYCLES);
               end
            end
            DRAIN: begin
               // The downstream empty flag is stale until the link round
               // trip has elapsed, so it is ignored while counting.
               if (drain_cnt != '0)
                  drain_cnt <= drain_cnt - CNT_W'(1);
               else if (alloc_q)
                  state <= FREE;
            end
            default: state <= FREE;
         endcase
      end
   end

   assign is_allocatable = (state == FREE) && alloc_q;
   assign is_on_off      = on_off_q && ((state == RESERVED) || (state == ACTIVE));
   assign error          = error_q;

endmodule

// File: rtl/output_port_tx.sv
// Transmit end of an inter-router link: registers crossbar flits onto the
// link and tracks each downstream VC for the switch and VC allocators.
module output_port_tx
   import noc_params::flit_t;
   import noc_params::flit_label_t;
   import output_port_tx_pkg::*;
#(
   parameter int VC_NUM       = noc_params::VC_NUM,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   output_port_tx_if.slave   link
);

   flit_t              data_q;
   logic               valid_q;
   logic [VC_NUM-1:0]  on_off_q;
   logic [VC_NUM-1:0]  alloc_q;
   logic [VC_NUM-1:0]  flit_hit;
   logic               grant_collision;
   logic [VC_NUM-1:0]  is_on_off;
   logic [VC_NUM-1:0]  is_allocatable;
   logic [VC_NUM-1:0]  error;

   // Link register: one cycle of latency, data held between flits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= link.xb_valid_i;
         if (link.xb_valid_i)
            data_q <= link.xb_flit_i;
      end
   end

   // Downstream status is registered once before use.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         on_off_q <= '0;
         alloc_q  <= '0;
      end else begin
         on_off_q <= link.on_off_i;
         alloc_q  <= link.vc_allocatable_i;
      end
   end

   // Route the incoming flit to the tracker of its VC.
   always_comb begin
      flit_hit = '0;
      if (link.xb_valid_i)
         flit_hit[link.xb_flit_i.vc_id] = 1'b1;
   end

   assign grant_collision = multi_hot(link.va_grant_i);

   for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      tx_vc_tracker #(
         .DRAIN_CYCLES (DRAIN_CYCLES)
      ) u_tracker (
         .clk             (clk),
         .rst             (rst),
         .grant           (link.va_grant_i[v]),
         .grant_collision (grant_collision),
         .flit_hit        (flit_hit[v]),
         .flit_label      (link.xb_flit_i.flit_label),
         .on_off_q        (on_off_q[v]),
         .alloc_q         (alloc_q[v]),
         .is_on_off       (is_on_off[v]),
         .is_allocatable  (is_allocatable[v]),
         .error           (error[v])
      );
   end

   assign link.data_o           = data_q;
   assign link.valid_flit_o     = valid_q;
   assign link.is_on_off_o      = is_on_off;
   assign link.is_allocatable_o = is_allocatable;
   assign link.error_o          = error;

endmodule

// File: tb/tb_output_port_tx.sv
// Self-checking bench for output_port_tx: flits go through a scoreboard
// queue, VC status and error vectors are checked against hand-derived values.
module tb_output_port_tx;
   import noc_params::*;

   localparam int DRAIN_CYCLES = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   output_port_tx_if bus ();

   output_port_tx #(
      .VC_NUM       (VC_NUM),
      .DRAIN_CYCLES (DRAIN_CYCLES)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .link (bus)
   );

   int    n_cmp = 0;
   int    n_err = 0;
   flit_t exp_q[$];
   flit_t last_data;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic flit_t mk(input flit_label_t l, input int vc, input logic [15:0] d);
      flit_t f;
      f.flit_label = l;
      f.vc_id      = VC_SIZE'(vc);
      f.data       = d;
      return f;
   endfunction

   task automatic send(input flit_label_t l, input int vc, input logic [15:0] d);
      bus.xb_flit_i  = mk(l, vc, d);
      bus.xb_valid_i = 1'b1;
   endtask

   // One clock: record any flit driven, step past the edge, then compare
   // the link output with the scoreboard. Flit valid and grants are pulses.
   task automatic tick();
      logic  sent;
      flit_t f;
      sent = bus.xb_valid_i && rst;
      f    = bus.xb_flit_i;
      if (sent)
         exp_q.push_back(f);
      @(posedge clk);
      #1;
      check("valid", bus.valid_flit_o, sent);
      if (bus.valid_flit_o) begin
         if (exp_q.size() > 0) begin
            f = exp_q.pop_front();
            check("flit", bus.data_o, f);
            last_data = f;
         end else begin
            check("sb_underflow", exp_q.size(), 1);
         end
      end else begin
         check("hold", bus.data_o, last_data);
      end
      bus.xb_valid_i = 1'b0;
      bus.va_grant_i = '0;
   endtask

   task automatic status(input string tag, input logic [3:0] on_off,
                         input logic [3:0] alloc, input logic [3:0] err);
      check({tag, ".on_off"}, bus.is_on_off_o, on_off);
      check({tag, ".alloc"},  bus.is_allocatable_o, alloc);
      check({tag, ".error"},  bus.error_o, err);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      last_data            = '0;
      bus.xb_flit_i        = '0;
      bus.xb_valid_i       = 1'b0;
      bus.va_grant_i       = '0;
      bus.on_off_i         = 4'b1111;
      bus.vc_allocatable_i = 4'b1111;
      rst = 1'b1;
      #1 rst = 1'b0;
      #2;
      status("reset", 4'b0000, 4'b0000, 4'b0000);
      check("reset.valid", bus.valid_flit_o, 1'b0);
      tick();
      tick();
      status("in_reset", 4'b0000, 4'b0000, 4'b0000);

      // Release: status registers load on the first edge.
      rst = 1'b1;
      tick();
      status("release", 4'b0000, 4'b1111, 4'b0000);

      // Full packet on VC 2 with downstream reporting non-empty meanwhile.
      bus.va_grant_i = 4'b0100;
      tick();
      status("vc2_grant", 4'b0100, 4'b1011, 4'b0000);
      bus.vc_allocatable_i = 4'b1011;
      send(HEAD, 2, 16'hA001); tick();
      status("vc2_head", 4'b0100, 4'b1011, 4'b0000);
      send(BODY, 2, 16'hA002); tick();
      send(BODY, 2, 16'hA003); tick();
      status("vc2_body", 4'b0100, 4'b1011, 4'b0000);
      send(TAIL, 2, 16'hA004); tick();
      status("vc2_tail", 4'b0000, 4'b1011, 4'b0000);
      bus.vc_allocatable_i = 4'b1111;
      tick();
      check("vc2_drain1", bus.is_allocatable_o, 4'b1011);
      tick();
      check("vc2_drain2", bus.is_allocatable_o, 4'b1011);
      tick();
      status("vc2_free", 4'b0000, 4'b1111, 4'b0000);

      // Single-flit packet on VC 0.
      bus.va_grant_i = 4'b0001;
      tick();
      status("vc0_grant", 4'b0001, 4'b1110, 4'b0000);
      send(HEADTAIL, 0, 16'hB0B0); tick();
      status("vc0_headtail", 4'b0000, 4'b1110, 4'b0000);
      tick();
      tick();
      check("vc0_drain", bus.is_allocatable_o, 4'b1110);
      tick();
      status("vc0_free", 4'b0000, 4'b1111, 4'b0000);

      // Back-pressure on VC 1 mid-packet.
      bus.va_grant_i = 4'b0010;
      tick();
      send(HEAD, 1, 16'hC001); tick();
      status("vc1_head", 4'b0010, 4'b1101, 4'b0000);
      bus.on_off_i = 4'b1101;
      send(BODY, 1, 16'hC002); tick();
      status("vc1_off", 4'b0000, 4'b1101, 4'b0000);
      send(BODY, 1, 16'hC003); tick();
      status("vc1_body_off", 4'b0000, 4'b1101, 4'b0010);
      bus.on_off_i = 4'b1111;
      tick();
      status("vc1_on", 4'b0010, 4'b1101, 4'b0010);
      send(TAIL, 1, 16'hC004); tick();
      status("vc1_tail", 4'b0000, 4'b1101, 4'b0010);

      // Flit on a FREE VC; VC 1 finishes draining meanwhile.
      send(BODY, 3, 16'hD003); tick();
      check("vc3_free_flit", bus.error_o, 4'b1010);
      tick();
      tick();
      status("sticky", 4'b0000, 4'b1111, 4'b1010);

      // Grant on an ACTIVE VC.
      bus.va_grant_i = 4'b0100;
      tick();
      send(HEAD, 2, 16'hE001); tick();
      bus.va_grant_i = 4'b0100;
      tick();
      status("vc2_regrant", 4'b0100, 4'b1011, 4'b1110);

      // Asynchronous reset right after a flit, between edges.
      send(BODY, 2, 16'hE002); tick();
      check("pre_reset.valid", bus.valid_flit_o, 1'b1);
      rst = 1'b0;
      #1;
      check("async.valid", bus.valid_flit_o, 1'b0);
      check("async.data", bus.data_o, 0);
      status("async", 4'b0000, 4'b0000, 4'b0000);
      last_data = '0;
      tick();
      rst = 1'b1;
      tick();
      status("after_reset", 4'b0000, 4'b1111, 4'b0000);

      // Two grants at once: both flagged, neither taken.
      bus.va_grant_i = 4'b0011;
      tick();
      status("multi_grant", 4'b0000, 4'b1111, 4'b0011);

      // Grant and first flit on the same VC in one cycle.
      bus.va_grant_i = 4'b0100;
      send(HEAD, 2, 16'hF001); tick();
      status("grant_flit_same", 4'b0100, 4'b1011, 4'b0111);

      // Grant on VC 3 alongside a legal flit on VC 2.
      bus.va_grant_i = 4'b1000;
      send(HEAD, 2, 16'hF002); tick();
      status("grant_flit_diff", 4'b1100, 4'b0011, 4'b0111);
      send(TAIL, 2, 16'hF003); tick();
      status("final", 4'b1000, 4'b0011, 4'b0111);

      check("sb_drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
